br_ram_addr_decoder_flow: RTL and testbench

Pipelined, flow-controlled address decoder for depth-tiled RAMs. Steers one push transaction (address plus sideband data) to exactly one of `Tiles` tile ports through a tree of registered fanout stages, with valid/ready backpressure at every stage. Tiles may be non-power-of-2 deep at the top end, and out-of-range accesses are detected. It sits between a RAM front-end (FIFO or arbiter) and the per-tile flops/SRAM macros.

---
 rtl/br_ram_addr_decoder_flow_pkg.sv | 25 ++
 rtl/br_ram_addr_decoder_flow_if.sv | 28 ++
 rtl/br_ram_addr_decoder_flow_stage.sv | 56 +++++
 rtl/br_ram_addr_decoder_flow.sv | 97 +++++++++
 tb/tb_br_ram_addr_decoder_flow.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/br_ram_addr_decoder_flow_pkg.sv
// br_ram_addr_decoder_pkg: derived-geometry helpers for the flow-controlled RAM address decoder.
package br_ram_addr_decoder_pkg;

    function automatic int calc_stages(int tiles, int fanout);
        int s = 0;
        int n = 1;
        if (fanout <= 1) return 1;
        while (n < tiles) begin
            n *= fanout;
            s++;
        end
        return s;
    endfunction

    function automatic int calc_tile_aw(int depth, int tiles);
        return $clog2(depth) - $clog2(tiles);
    endfunction

    // Only the last tile may be partially populated.
    function automatic int tile_depth(int depth, int tiles, int t);
        int full = 1 << calc_tile_aw(depth, tiles);
        return (t == tiles - 1) ? depth - (tiles - 1) * full : full;
    endfunction

endpackage

// File: rtl/br_ram_addr_decoder_flow_if.sv
// br_ram_addr_decoder_flow_if: push side, per-tile side and out-of-range status of the decoder.
interface br_ram_addr_decoder_flow_if #(
    parameter int Tiles = 1,
    parameter int AddressWidth = 1,
    parameter int TileAddressWidth = 1,
    parameter int DataWidth = 1
);
    logic push_valid;
    logic push_ready;
    logic [AddressWidth-1:0] push_addr;
    logic [DataWidth-1:0] push_data;
    logic [Tiles-1:0] tile_valid;
    logic [Tiles-1:0] tile_ready;
    logic [Tiles-1:0][TileAddressWidth-1:0] tile_addr;
    logic [Tiles-1:0][DataWidth-1:0] tile_data;
    logic oor_drop;
    logic [15:0] oor_count;

    modport master (
        output push_valid, push_addr, push_data, tile_ready,
        input push_ready, tile_valid, tile_addr, tile_data, oor_drop, oor_count
    );

    modport slave (
        input push_valid, push_addr, push_data, tile_ready,
        output push_ready, tile_valid, tile_addr, tile_data, oor_drop, oor_count
    );
endinterface

// File: rtl/br_ram_addr_decoder_flow_stage.sv
// br_ram_addr_decoder_flow_stage: one input lane fanned out to Fanout one-entry pipe registers.
module br_ram_addr_decoder_flow_stage #(
    parameter int Fanout = 2,
    parameter int InWidth = 2,
    parameter int DataWidth = 1,
    localparam int SelWidth = Fanout > 1 ? $clog2(Fanout) : 0,
    localparam int OutWidth = InWidth - SelWidth
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [InWidth-1:0] in_addr,
    input  logic [DataWidth-1:0] in_data,
    output logic [Fanout-1:0] out_valid,
    input  logic [Fanout-1:0] out_ready,
    output logic [Fanout-1:0][OutWidth-1:0] out_addr,
    output logic [Fanout-1:0][DataWidth-1:0] out_data
);
    localparam int SelBits = SelWidth > 0 ? SelWidth : 1;

    logic [SelBits-1:0] sel;
    logic [Fanout-1:0] sel_oh;
    logic [Fanout-1:0] load;

    if (Fanout > 1) begin : g_sel
        assign sel = in_addr[InWidth-1 -: SelWidth];
    end else begin : g_sel
        assign sel = 1'b0;
    end

    always_comb begin
        sel_oh = '0;
        for (int b = 0; b < Fanout; b++) sel_oh[b] = sel == SelBits'(b);
    end

    // Ready follows only the selected branch, so a stalled branch blocks the whole lane.
    assign load = {Fanout{in_valid}} & sel_oh & (~out_valid | out_ready);
    assign in_ready = |(sel_oh & (~out_valid | out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            for (int b = 0; b < Fanout; b++) begin
                if (load[b] || out_ready[b]) out_valid[b] <= load[b];
                if (load[b]) begin
                    out_addr[b] <= in_addr[OutWidth-1:0];
                    out_data[b] <= in_data;
                end
            end
        end
    end
endmodule

// File: rtl/br_ram_addr_decoder_flow.sv
// br_ram_addr_decoder_flow: pipelined valid/ready address decoder steering pushes to depth tiles.
// Define BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN to drop and count out-of-range pushes.
module br_ram_addr_decoder_flow import br_ram_addr_decoder_pkg::*; #(
    parameter int Depth = 2,
    parameter int DataWidth = 1,
    parameter int Tiles = 1,
    parameter int FanoutPerStage = Tiles,
    localparam int AddressWidth = $clog2(Depth),
    localparam int TileAddressWidth = calc_tile_aw(Depth, Tiles),
    localparam int Stages = calc_stages(Tiles, FanoutPerStage),
    localparam int SelW = FanoutPerStage > 1 ? $clog2(FanoutPerStage) : 0
) (
    input logic clk,
    input logic rst_n,
    br_ram_addr_decoder_flow_if.slave bus
);
    logic in_range;
    logic s0_valid;
    logic s0_ready;

`ifdef BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN
    assign in_range = {1'b0, bus.push_addr} < (AddressWidth + 1)'(Depth);
    assign bus.oor_drop = rst_n && bus.push_valid && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.oor_count <= '0;
        else if (bus.oor_drop && bus.oor_count != 16'hFFFF) bus.oor_count <= bus.oor_count + 16'd1;
    end
`else
    assign in_range = 1'b1;
    assign bus.oor_drop = 1'b0;
    assign bus.oor_count = '0;

    assert property (@(posedge clk) disable iff (!rst_n)
        bus.push_valid |-> {1'b0, bus.push_addr} < (AddressWidth + 1)'(Depth));
`endif

    // Out-of-range pushes are swallowed here and never reach the tree.
    assign s0_valid = bus.push_valid && in_range;
    assign bus.push_ready = !in_range || s0_ready;

    for (genvar s = 0; s < Stages; s++) begin : g_stage
        localparam int Lanes = FanoutPerStage ** s;
        localparam int InW = AddressWidth - s * SelW;
        localparam int OutW = InW - SelW;

        logic [Lanes-1:0] iv;
        logic [Lanes-1:0] ir;
        logic [Lanes-1:0][InW-1:0] ia;
        logic [Lanes-1:0][DataWidth-1:0] id;
        logic [Lanes*FanoutPerStage-1:0] ov;
        logic [Lanes*FanoutPerStage-1:0] ordy;
        logic [Lanes*FanoutPerStage-1:0][OutW-1:0] oa;
        logic [Lanes*FanoutPerStage-1:0][DataWidth-1:0] od;

        if (s == 0) begin : g_in
            assign iv = s0_valid;
            assign ia = bus.push_addr;
            assign id = bus.push_data;
            assign s0_ready = ir;
        end else begin : g_in
            assign iv = g_stage[s-1].ov;
            assign ia = g_stage[s-1].oa;
            assign id = g_stage[s-1].od;
        end

        if (s == Stages - 1) begin : g_out
            assign ordy = bus.tile_ready;
        end else begin : g_out
            assign ordy = g_stage[s+1].ir;
        end

        // Branch b of lane l feeds lane l*Fanout+b of the next stage.
        for (genvar l = 0; l < Lanes; l++) begin : g_lane
            br_ram_addr_decoder_flow_stage #(
                .Fanout(FanoutPerStage),
                .InWidth(InW),
                .DataWidth(DataWidth)
            ) u_stage (
                .clk(clk),
                .rst_n(rst_n),
                .in_valid(iv[l]),
                .in_ready(ir[l]),
                .in_addr(ia[l]),
                .in_data(id[l]),
                .out_valid(ov[l*FanoutPerStage +: FanoutPerStage]),
                .out_ready(ordy[l*FanoutPerStage +: FanoutPerStage]),
                .out_addr(oa[l*FanoutPerStage +: FanoutPerStage]),
                .out_data(od[l*FanoutPerStage +: FanoutPerStage])
            );
        end
    end

    assign bus.tile_valid = g_stage[Stages-1].ov;
    assign bus.tile_addr = g_stage[Stages-1].oa;
    assign bus.tile_data = g_stage[Stages-1].od;
endmodule

// File: tb/tb_br_ram_addr_decoder_flow.sv
// tb_br_ram_addr_decoder_flow: directed scoreboard bench, Depth=14 Tiles=4 Fanout=2.
// OOR steps are active only when BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN is defined.
module tb_br_ram_addr_decoder_flow;
    localparam int Depth = 14;
    localparam int DataWidth = 8;
    localparam int Tiles = 4;
    localparam int Fanout = 2;
    localparam int AW = 4;
    localparam int TAW = 2;

    typedef struct packed {
        int acc;
        logic [DataWidth-1:0] d;
        logic [TAW-1:0] a;
    } exp_t;

    logic clk = 0;
    logic rst_n = 1;
    always #5 clk = ~clk;

    br_ram_addr_decoder_flow_if #(
        .Tiles(Tiles), .AddressWidth(AW), .TileAddressWidth(TAW), .DataWidth(DataWidth)
    ) bus ();

    br_ram_addr_decoder_flow #(
        .Depth(Depth), .DataWidth(DataWidth), .Tiles(Tiles), .FanoutPerStage(Fanout)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t sb [Tiles][$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_oor = 0;
    bit lat_chk = 0;
    logic [Tiles-1:0] pstall = '0;
    logic [TAW-1:0] pa [Tiles];
    logic [DataWidth-1:0] pd [Tiles];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN
        return exp_oor > 65535 ? 65535 : exp_oor;
`else
        return 0;
`endif
    endfunction

    function automatic int total();
        int n = 0;
        for (int t = 0; t < Tiles; t++) n += sb[t].size();
        return n;
    endfunction

    // Output monitor: pops the scoreboard on each tile handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) pstall = '0;
        else for (int t = 0; t < Tiles; t++) begin
            if (pstall[t]) begin
                chk("hold_valid", 64'(bus.tile_valid[t]), 1);
                chk("hold_addr", 64'(bus.tile_addr[t]), 64'(pa[t]));
                chk("hold_data", 64'(bus.tile_data[t]), 64'(pd[t]));
            end
            if (bus.tile_valid[t] && bus.tile_ready[t]) begin
                chk("tile_expected", 64'(sb[t].size() != 0), 1);
                if (sb[t].size() != 0) begin
                    mon_e = sb[t].pop_front();
                    chk("tile_addr", 64'(bus.tile_addr[t]), 64'(mon_e.a));
                    chk("tile_data", 64'(bus.tile_data[t]), 64'(mon_e.d));
                    if (lat_chk) chk("latency", 64'(cyc - mon_e.acc), 2);
                end
            end
            pstall[t] = bus.tile_valid[t] && !bus.tile_ready[t];
            pa[t] = bus.tile_addr[t];
            pd[t] = bus.tile_data[t];
        end
    end

    task automatic push(input logic [AW-1:0] addr, input logic [DataWidth-1:0] data);
        bit done = 0;
        bus.push_valid = 1;
        bus.push_addr = addr;
        bus.push_data = data;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.push_ready) begin
                done = 1;
                if (int'(addr) >= Depth) exp_oor++;
                else sb[int'(addr) >> TAW].push_back('{acc: cyc, d: data, a: addr[TAW-1:0]});
            end
            @(posedge clk); #1;
        end
        if (!done) chk("push_timeout", 64'(bus.push_ready), 1);
    endtask

    task automatic idle(input int n);
        bus.push_valid = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && total() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(total()), 0);
    endtask

    initial begin
        int c0;
        bus.push_valid = 0;
        bus.push_addr = '0;
        bus.push_data = '0;
        bus.tile_ready = '1;
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tile_valid", 64'(bus.tile_valid), 0);
        chk("rst_tile_addr", 64'(bus.tile_addr), 0);
        chk("rst_tile_data", 64'(bus.tile_data), 0);
        chk("rst_push_ready", 64'(bus.push_ready), 1);
        chk("rst_oor_drop", 64'(bus.oor_drop), 0);
        chk("rst_oor_count", 64'(bus.oor_count), 0);
        rst_n = 1;
        idle(1);

        // Back-to-back sweep of every in-range address, one accept per cycle.
        lat_chk = 1;
        for (int a = 0; a < Depth; a++) begin
            c0 = cyc;
            push(AW'(a), DataWidth'(a * 7 + 1));
            chk("throughput", 64'(cyc - c0), 1);
        end
        idle(1);
        drain();
        lat_chk = 0;

`ifdef BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN
        bus.push_valid = 1;
        bus.push_addr = 4'd14;
        bus.push_data = 8'hEE;
        @(negedge clk);
        chk("oor_ready", 64'(bus.push_ready), 1);
        chk("oor_drop_pulse", 64'(bus.oor_drop), 1);
        exp_oor++;
        @(posedge clk); #1;
        bus.push_valid = 0;
        @(negedge clk);
        chk("oor_drop_end", 64'(bus.oor_drop), 0);
        chk("oor_count_1", 64'(bus.oor_count), 64'(exp_cnt()));
        repeat (2) @(negedge clk);
        chk("oor_no_tile", 64'(bus.tile_valid), 0);
        @(posedge clk); #1;
`endif
        push(4'd13, 8'hD3);
        idle(1);
        drain();

        // Stall tile 1: two accepts fill its path, the third push is held off.
        bus.tile_ready = 4'b1101;
        push(4'd4, 8'h40);
        push(4'd5, 8'h50);
        bus.push_valid = 1;
        bus.push_addr = 4'd6;
        bus.push_data = 8'h60;
        repeat (3) begin
            @(negedge clk);
            chk("stall_push_ready", 64'(bus.push_ready), 0);
            @(posedge clk); #1;
        end
        chk("stall_tile1_valid", 64'(bus.tile_valid[1]), 1);
        chk("stall_tile1_addr", 64'(bus.tile_addr[1]), 0);
        bus.tile_ready = '1;
        push(4'd6, 8'h60);
        idle(1);
        drain();

        // Head-of-line: tile 0 stalled; tile 2 lives on the other root branch, tile 1 does not.
        bus.tile_ready = 4'b1110;
        push(4'd0, 8'h01);
        push(4'd1, 8'h11);
        c0 = cyc;
        push(4'd8, 8'h81);
        chk("hol_other_branch", 64'(cyc - c0), 1);
        bus.push_valid = 1;
        bus.push_addr = 4'd4;
        bus.push_data = 8'h44;
        repeat (2) begin
            @(negedge clk);
            chk("hol_blocked", 64'(bus.push_ready), 0);
            @(posedge clk); #1;
        end
        bus.tile_ready = '1;
        push(4'd4, 8'h44);
        idle(1);
        drain();

        // Reset with two transactions in flight.
        push(4'd2, 8'h22);
        push(4'd6, 8'h66);
        bus.push_valid = 0;
        rst_n = 0;
        for (int t = 0; t < Tiles; t++) sb[t].delete();
        exp_oor = 0;
        #1;
        chk("midrst_tile_valid", 64'(bus.tile_valid), 0);
        chk("midrst_push_ready", 64'(bus.push_ready), 1);
        chk("midrst_oor_count", 64'(bus.oor_count), 0);
        @(posedge clk); #1;
        rst_n = 1;
        idle(3);
        chk("midrst_no_replay", 64'(bus.tile_valid), 0);
        push(4'd9, 8'h99);
        idle(1);
        drain();

`ifdef BR_RAM_ADDR_DECODER_FLOW_OOR_CHECK_EN
        bus.push_valid = 1;
        bus.push_addr = 4'd15;
        repeat (65534) @(posedge clk);
        #1;
        exp_oor += 65534;
        chk("oor_count_near_sat", 64'(bus.oor_count), 64'(exp_cnt()));
        repeat (6) @(posedge clk);
        #1;
        exp_oor += 6;
        bus.push_valid = 0;
        chk("oor_count_sat", 64'(bus.oor_count), 64'(exp_cnt()));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
